// File: rtl/sisc_mc_pkg.sv
// Shared encodings for the multi-cycle SISC core: opcodes, ALU ops, flag
// positions, instruction field offsets and the control FSM state type.
package sisc_mc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_RR   = 4'h1;
    localparam logic [3:0] OP_RI   = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] MM_ADD = 4'd0;
    localparam logic [3:0] MM_SUB = 4'd1;
    localparam logic [3:0] MM_AND = 4'd2;
    localparam logic [3:0] MM_OR  = 4'd3;
    localparam logic [3:0] MM_XOR = 4'd4;
    localparam logic [3:0] MM_NOT = 4'd5;
    localparam logic [3:0] MM_SLL = 4'd6;
    localparam logic [3:0] MM_SRL = 4'd7;
    localparam logic [3:0] MM_SRA = 4'd8;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam int OPC_LSB = 28;
    localparam int MM_LSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

    function automatic logic mm_legal(input logic [3:0] mm);
        return mm <= MM_SRA;
    endfunction

endpackage

// File: rtl/sisc_mc_core_if.sv
// Instruction handshake and status bundle between an issuing master and the core.
interface sisc_mc_core_if;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic        halted;
    logic        illegal;
    logic [3:0]  stat;

    modport master (output instruction, instr_valid,
                    input  instr_ready, done, halted, illegal, stat);
    modport slave  (input  instruction, instr_valid,
                    output instr_ready, done, halted, illegal, stat);
endinterface

// File: rtl/sisc_alu_p.sv
// Combinational ALU: result and {C,N,Z,V} flags for one operation.
module sisc_alu_p
    import sisc_mc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        mm_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);
    localparam int M = DATA_W - 1;
    localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);

    logic [DATA_W-1:0] shamt;
    logic [DATA_W:0]   sum, diff, sll_ext, srl_ext, sra_ext;
    logic              c, v;

    always_comb begin
        shamt   = b_i % DW;
        sum     = {1'b0, a_i} + {1'b0, b_i};
        diff    = {1'b0, a_i} - {1'b0, b_i};
        // One guard bit on the exit side captures the last bit shifted out.
        sll_ext = {1'b0, a_i} << shamt;
        srl_ext = {a_i, 1'b0} >> shamt;
        sra_ext = $signed({a_i, 1'b0}) >>> shamt;
        result_o = '0;
        c = 1'b0;
        v = 1'b0;
        case (mm_i)
            MM_ADD: begin
                result_o = sum[M:0];
                c = sum[DATA_W];
                v = (a_i[M] == b_i[M]) && (result_o[M] != a_i[M]);
            end
            MM_SUB: begin
                result_o = diff[M:0];
                c = ~diff[DATA_W];
                v = (a_i[M] != b_i[M]) && (result_o[M] != a_i[M]);
            end
            MM_AND: result_o = a_i & b_i;
            MM_OR:  result_o = a_i | b_i;
            MM_XOR: result_o = a_i ^ b_i;
            MM_NOT: result_o = ~a_i;
            MM_SLL: begin
                result_o = sll_ext[M:0];
                c = sll_ext[DATA_W];
            end
            MM_SRL: begin
                result_o = srl_ext[DATA_W:1];
                c = srl_ext[0];
            end
            MM_SRA: begin
                result_o = sra_ext[DATA_W:1];
                c = sra_ext[0];
            end
            default: ;
        endcase
        flags_o         = '0;
        flags_o[FLAG_C] = c;
        flags_o[FLAG_N] = result_o[M];
        flags_o[FLAG_Z] = (result_o == '0);
        flags_o[FLAG_V] = v;
    end
endmodule

// File: rtl/sisc_mc_core.sv
// Multi-cycle SISC core: register file, status register and the
// IDLE/DECODE/EXECUTE/WRITEBACK control FSM around sisc_alu_p.
module sisc_mc_core
    import sisc_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    sisc_mc_core_if.slave     bus,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_e            state_q, state_d;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] opa_q, opb_q, res_q;
    logic [3:0]        flags_q, stat_q;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic [DATA_W-1:0] rf_view [16];

    logic [3:0]        opcode, mm, rd, rs, rt, alu_mm;
    logic [DATA_W-1:0] imm_sext, alu_res;
    logic [3:0]        alu_flags;
    logic              op_writes, op_flags;

    // Full 16-entry read view; R0 and unimplemented indices read as zero.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_view
            if (gi > 0 && gi < NREGS) begin : g_impl
                assign rf_view[gi] = regs_q[gi];
            end else begin : g_zero
                assign rf_view[gi] = '0;
            end
        end
    endgenerate

    assign opcode    = instr_q[OPC_LSB +: 4];
    assign mm        = instr_q[MM_LSB +: 4];
    assign rd        = instr_q[RD_LSB +: 4];
    assign rs        = instr_q[RS_LSB +: 4];
    assign rt        = instr_q[RT_LSB +: 4];
    assign imm_sext  = DATA_W'($signed(instr_q[15:0]));
    assign op_writes = (opcode == OP_RR) || (opcode == OP_RI);
    assign op_flags  = op_writes || (opcode == OP_CMP);
    assign alu_mm    = (opcode == OP_CMP) ? MM_SUB : mm;

    always_comb begin
        illegal_d = 1'b0;
        case (opcode)
            OP_NOP, OP_CMP, OP_HALT: illegal_d = 1'b0;
            OP_RR, OP_RI:            illegal_d = !mm_legal(mm);
            default:                 illegal_d = 1'b1;
        endcase
    end

    sisc_alu_p #(.DATA_W(DATA_W)) u_alu (
        .a_i      (opa_q),
        .b_i      (opb_q),
        .mm_i     (alu_mm),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (bus.instr_valid) state_d = ST_DECODE;
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = (opcode == OP_HALT) ? ST_HALTED : ST_IDLE;
            ST_HALTED:    state_d = ST_HALTED;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            stat_q    <= '0;
            illegal_q <= 1'b0;
            for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (bus.instr_valid) instr_q <= bus.instruction;
                ST_DECODE: begin
                    opa_q <= rf_view[rs];
                    opb_q <= (opcode == OP_RI) ? imm_sext : rf_view[rt];
                end
                ST_EXECUTE: begin
                    res_q     <= alu_res;
                    flags_q   <= alu_flags;
                    illegal_q <= illegal_d;
                end
                ST_WRITEBACK: if (!illegal_q) begin
                    if (op_flags) stat_q <= flags_q;
                    // rd of 0 or >= NREGS matches no slot, so the write drops.
                    for (int i = 1; i < NREGS; i++)
                        if (op_writes && int'(rd) == i) regs_q[i] <= res_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = rst_f && (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_WRITEBACK);
    assign bus.illegal     = (state_q == ST_WRITEBACK) && illegal_q;
    assign bus.halted      = (state_q == ST_HALTED);
    assign bus.stat        = stat_q;
    assign dbg_data        = rf_view[dbg_addr];
endmodule
